// File: rtl/adder_8_pkg.sv
// Shared constants and types for the 8-bit adder core.
//   DATA_W    : operand / sum width
//   add_rsp_t : bundled adder result {sum, carry-out, signed overflow}
package adder_8_pkg;
  localparam int DATA_W = 8;

  typedef struct packed {
    logic [DATA_W-1:0] sum;
    logic              c1;
    logic              ovf;
  } add_rsp_t;
endpackage

// File: rtl/adder_8_full_adder.sv
// One-bit full adder, the ripple-chain cell of adder_8.
//   a, b : operand bits
//   cin  : carry in from the stage below
//   s    : sum bit
//   cout : carry out to the stage above
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  logic p;

  // Propagate term is shared by the sum and the carry.
  assign p    = a ^ b;
  assign s    = p ^ cin;
  assign cout = (a & b) | (cin & p);
endmodule

// File: rtl/adder_8.sv
// 8-bit ripple-carry adder, arithmetic core of the ALU.
// The caller handles subtraction by inverting b and setting c0; this block
// never inverts anything itself.
//   clock, reset     : clock and sync active-high reset, registered copy only
//   a, b, c0         : addends and carry-in
//   out, c1, ovf     : combinational sum, carry-out, signed overflow
//   out_q, c1_q, ovf_q : the same three values, registered one cycle later
module adder_8
  import adder_8_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              c0,
  output logic [DATA_W-1:0] out,
  output logic              c1,
  output logic              ovf,
  output logic [DATA_W-1:0] out_q,
  output logic              c1_q,
  output logic              ovf_q
);
  // c[i] is the carry into stage i; c[DATA_W] is the final carry-out.
  logic [DATA_W:0] c;
  add_rsp_t        rsp_d;
  // Power-up value matches the reset value.
  add_rsp_t        rsp_q = '0;

  assign c[0] = c0;

  for (genvar i = 0; i < DATA_W; i++) begin : g_fa
    full_adder u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (c[i]),
      .s    (out[i]),
      .cout (c[i+1])
    );
  end

  assign c1  = c[DATA_W];
  // Signed overflow: carry into the sign bit differs from carry out of it.
  assign ovf = c[DATA_W-1] ^ c[DATA_W];

  assign rsp_d = '{sum: out, c1: c1, ovf: ovf};

  always_ff @(posedge clock) begin
    if (reset) rsp_q <= '0;
    else       rsp_q <= rsp_d;
  end

  assign out_q = rsp_q.sum;
  assign c1_q  = rsp_q.c1;
  assign ovf_q = rsp_q.ovf;
endmodule

// File: tb/tb_adder_8.sv
module tb_adder_8;
  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] a = '0, b = '0;
  logic       c0 = 1'b0;
  logic [7:0] out, out_q;
  logic       c1, ovf, c1_q, ovf_q;

  int checks = 0;
  int failures = 0;

  adder_8 dut (
    .clock (clock), .reset (reset),
    .a (a), .b (b), .c0 (c0),
    .out (out), .c1 (c1), .ovf (ovf),
    .out_q (out_q), .c1_q (c1_q), .ovf_q (ovf_q)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       rst;
    logic [7:0] a, b;
    logic       c0;
    logic [7:0] eo;
    logic       ec1, eov;
  } vec_t;

  typedef struct {
    string      name;
    logic [7:0] eo;
    logic       ec1, eov;
    logic [7:0] qo;
    logic       qc1, qov;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  bit   directed_done = 0;

  function automatic vec_t mk(logic r, logic [7:0] va, logic [7:0] vb, logic vc,
                              logic [7:0] eo, logic ec1, logic eov);
    vec_t v;
    v.rst = r; v.a = va; v.b = vb; v.c0 = vc;
    v.eo = eo; v.ec1 = ec1; v.eov = eov;
    return v;
  endfunction

  // Monitor: at each falling edge the current vector's combinational result
  // is checked, and the registered result of the previous vector.
  initial begin
    exp_t cur, prev;
    bit   have_prev = 0;
    forever begin
      @(negedge clock);
      if (sb.size() > 0) begin
        cur = sb.pop_front();
        if (have_prev) begin
          checks++;
          if ({out_q, c1_q, ovf_q} !== {prev.qo, prev.qc1, prev.qov}) begin
            failures++;
            $display("FAIL reg_%s actual out_q=%h c1_q=%b ovf_q=%b expected out_q=%h c1_q=%b ovf_q=%b",
                     prev.name, out_q, c1_q, ovf_q, prev.qo, prev.qc1, prev.qov);
          end
        end
        checks++;
        if ({out, c1, ovf} !== {cur.eo, cur.ec1, cur.eov}) begin
          failures++;
          $display("FAIL comb_%s actual out=%h c1=%b ovf=%b expected out=%h c1=%b ovf=%b",
                   cur.name, out, c1, ovf, cur.eo, cur.ec1, cur.eov);
        end
        prev = cur;
        have_prev = 1;
      end
    end
  end

  initial begin
    int   nprint;
    exp_t e;
    logic [8:0] ref9;
    logic       ref_ovf;

    // Power-up value of the registered copy, before any clock edge.
    #1;
    checks++;
    if ({out_q, c1_q, ovf_q} !== 10'h0) begin
      failures++;
      $display("FAIL powerup actual out_q=%h c1_q=%b ovf_q=%b expected 00 0 0", out_q, c1_q, ovf_q);
    end

    vecs.push_back(mk(1, 8'h00, 8'h00, 0, 8'h00, 0, 0)); // reset state
    vecs.push_back(mk(0, 8'h05, 8'h03, 0, 8'h08, 0, 0));
    vecs.push_back(mk(0, 8'hFF, 8'h01, 0, 8'h00, 1, 0));
    vecs.push_back(mk(0, 8'h7F, 8'h01, 0, 8'h80, 0, 1));
    vecs.push_back(mk(0, 8'h80, 8'hFF, 0, 8'h7F, 1, 1));
    vecs.push_back(mk(0, 8'h05, 8'hFC, 1, 8'h02, 1, 0)); // 5-3
    vecs.push_back(mk(0, 8'h03, 8'hFA, 1, 8'hFE, 0, 0)); // 3-5
    vecs.push_back(mk(0, 8'h2A, 8'hD5, 1, 8'h00, 1, 0)); // equal
    vecs.push_back(mk(0, 8'hFF, 8'h00, 1, 8'h00, 1, 0));
    vecs.push_back(mk(0, 8'hFF, 8'hFF, 1, 8'hFF, 1, 0));
    vecs.push_back(mk(0, 8'h00, 8'h00, 0, 8'h00, 0, 0));
    vecs.push_back(mk(1, 8'h10, 8'h20, 0, 8'h30, 0, 0)); // reset held
    vecs.push_back(mk(0, 8'h10, 8'h20, 0, 8'h30, 0, 0)); // release
    vecs.push_back(mk(0, 8'h00, 8'h00, 0, 8'h00, 0, 0)); // flush

    foreach (vecs[i]) begin
      @(posedge clock);
      #1;
      reset = vecs[i].rst; a = vecs[i].a; b = vecs[i].b; c0 = vecs[i].c0;
      e.name = $sformatf("v%0d_%h_%h_%b", i, vecs[i].a, vecs[i].b, vecs[i].c0);
      e.eo = vecs[i].eo; e.ec1 = vecs[i].ec1; e.eov = vecs[i].eov;
      // Registered copy is cleared when reset is high at the capture edge.
      e.qo  = vecs[i].rst ? 8'h00 : vecs[i].eo;
      e.qc1 = vecs[i].rst ? 1'b0  : vecs[i].ec1;
      e.qov = vecs[i].rst ? 1'b0  : vecs[i].eov;
      sb.push_back(e);
    end

    // Let the monitor drain, bounded.
    for (int k = 0; k < 50 && sb.size() > 0; k++) @(posedge clock);
    if (sb.size() > 0) begin
      checks++; failures++;
      $display("FAIL drain_timeout actual pending=%0d expected 0", sb.size());
    end
    @(negedge clock);
    @(posedge clock);
    #1;
    directed_done = 1;

    // Exhaustive combinational sweep against an arithmetic reference.
    nprint = 0;
    for (int ia = 0; ia < 256; ia++)
      for (int ib = 0; ib < 256; ib++)
        for (int ic = 0; ic < 2; ic++) begin
          a = ia[7:0]; b = ib[7:0]; c0 = ic[0];
          #1;
          ref9    = {1'b0, a} + {1'b0, b} + {8'b0, c0};
          ref_ovf = (a[7] == b[7]) && (ref9[7] != a[7]);
          checks++;
          if ({c1, out, ovf} !== {ref9, ref_ovf}) begin
            failures++;
            if (nprint < 10) begin
              nprint++;
              $display("FAIL sweep_%h_%h_%b actual c1=%b out=%h ovf=%b expected c1=%b out=%h ovf=%b",
                       a, b, c0, c1, out, ovf, ref9[8], ref9[7:0], ref_ovf);
            end
          end
        end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
